// File: rtl/segment_saver_display.sv
// segment_saver_display
//   NORMAL: seg/an follow the stopwatch drive (normal_seg/normal_an) one clk late.
//   SAVER : entered after IDLE_TICKS consecutive idle cycles; each idx_valid strobe
//           lights one segment (seg_idx) on one digit (digit pointer). After a
//           strobe with seg_idx=6 the pointer moves on to the next digit.
//   Any activity in SAVER returns to NORMAL.
// Optional build macro: SEG_SAVER_ACTIVE_LOW_EN -- seg/an are inverted at the
// output registers (reset value all-ones) for common-anode displays.
module segment_saver_display #(
    parameter int          N_DIGITS   = 4,
    parameter logic [31:0] IDLE_TICKS = 32'd500_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          seg_idx,
    input  logic                idx_valid,
    input  logic                activity,
    input  logic [6:0]          normal_seg,
    input  logic [N_DIGITS-1:0] normal_an,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                saver_active,
    output logic                idx_err
);

    localparam int PTR_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // NOTE: polarity is applied as an XOR mask on every value loaded into the
    // output registers, so the registers themselves hold the pin-level drive and
    // the rest of the logic is identical in both builds.
`ifdef SEG_SAVER_ACTIVE_LOW_EN
    localparam logic [6:0]          SEG_POL = '1;
    localparam logic [N_DIGITS-1:0] AN_POL  = '1;
`else
    localparam logic [6:0]          SEG_POL = '0;
    localparam logic [N_DIGITS-1:0] AN_POL  = '0;
`endif

    localparam logic [31:0]         IDLE_LAST = IDLE_TICKS - 32'd1;
    localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);
    localparam logic [6:0]          SEG_ONE   = 7'd1;
    localparam logic [3:0]          IDX_LAST  = 4'd6;

    typedef enum logic {
        NORMAL = 1'b0,
        SAVER  = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        idle_cnt;
    logic [PTR_W-1:0]   digit_ptr;

    // Mode FSM, idle counter, digit pointer and all registered outputs.
    // NOTE: every register here uses non-blocking assignment so all of them see
    // the pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the output registers reset to the "all off" pin level, so the
            // display is dark immediately, without waiting for a clock edge.
            state        <= NORMAL;
            idle_cnt     <= '0;
            digit_ptr    <= '0;
            seg          <= SEG_POL;
            an           <= AN_POL;
            saver_active <= 1'b0;
            idx_err      <= 1'b0;
        end else begin
            unique case (state)
                NORMAL: begin
                    if (activity) begin
                        // Activity beats a coincident timeout.
                        idle_cnt <= '0;
                        seg      <= normal_seg ^ SEG_POL;
                        an       <= normal_an ^ AN_POL;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state        <= SAVER;
                        saver_active <= 1'b1;
                        idle_cnt     <= '0;
                        digit_ptr    <= '0;
                        seg          <= SEG_POL;
                        an           <= AN_POL;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                        seg      <= normal_seg ^ SEG_POL;
                        an       <= normal_an ^ AN_POL;
                    end
                end

                SAVER: begin
                    if (activity) begin
                        // Leave the saver; outputs hold this cycle and pass
                        // through again from the next edge onwards.
                        state        <= NORMAL;
                        saver_active <= 1'b0;
                        idx_err      <= 1'b0;
                        idle_cnt     <= '0;
                    end else if (idx_valid) begin
                        if (seg_idx <= IDX_LAST) begin
                            seg <= (SEG_ONE << seg_idx[2:0]) ^ SEG_POL;
                            an  <= (AN_ONE << digit_ptr) ^ AN_POL;
                            if (seg_idx == IDX_LAST) begin
                                digit_ptr <= (digit_ptr == PTR_LAST) ? '0
                                                                     : digit_ptr + 1'b1;
                            end
                        end else begin
                            // Out-of-range index: blank and flag, pointer kept.
                            seg     <= SEG_POL;
                            an      <= AN_POL;
                            idx_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= NORMAL;
                    saver_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_saver_display.sv
// Self-checking bench for segment_saver_display (N_DIGITS=4, IDLE_TICKS=8).
// A behavioural model tracks mode, idle time, digit position and the expected
// display; directed scenarios plus a randomized run are compared against it.
module tb_segment_saver_display;

    localparam int          N_DIGITS = 4;
    localparam int          IDLE     = 8;

`ifdef SEG_SAVER_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_MASK = 7'h7F;
    localparam logic [3:0] AN_MASK  = 4'hF;
`else
    localparam logic [6:0] SEG_MASK = 7'h00;
    localparam logic [3:0] AN_MASK  = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] seg_idx;
    logic       idx_valid;
    logic       activity;
    logic [6:0] normal_seg;
    logic [3:0] normal_an;
    logic [6:0] seg;
    logic [3:0] an;
    logic       saver_active;
    logic       idx_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state (active-high view of the display).
    bit         m_saver;
    int         m_idle;
    int         m_digit;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    bit         m_err;

    segment_saver_display #(
        .N_DIGITS  (N_DIGITS),
        .IDLE_TICKS(32'd8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_idx     (seg_idx),
        .idx_valid   (idx_valid),
        .activity    (activity),
        .normal_seg  (normal_seg),
        .normal_an   (normal_an),
        .seg         (seg),
        .an          (an),
        .saver_active(saver_active),
        .idx_err     (idx_err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] observed();
        return {saver_active, idx_err, an, seg};
    endfunction

    function automatic logic [12:0] expected();
        return {m_saver, m_err, m_an ^ AN_MASK, m_seg ^ SEG_MASK};
    endfunction

    function automatic logic [12:0] pins(input bit sv, input bit er,
                                         input logic [3:0] a, input logic [6:0] s);
        return {sv, er, a ^ AN_MASK, s ^ SEG_MASK};
    endfunction

    task automatic model_reset();
        m_saver = 0; m_idle = 0; m_digit = 0; m_seg = '0; m_an = '0; m_err = 0;
    endtask

    // One clock of the display as described: idle timing, saver animation, exits.
    task automatic model_step(input bit act, input bit v, input int idx,
                              input logic [6:0] ns, input logic [3:0] na);
        if (!m_saver) begin
            if (!act && m_idle == IDLE - 1) begin
                m_saver = 1; m_idle = 0; m_digit = 0; m_seg = '0; m_an = '0;
            end else begin
                m_idle = act ? 0 : m_idle + 1;
                m_seg  = ns;
                m_an   = na;
            end
        end else if (act) begin
            m_saver = 0; m_err = 0; m_idle = 0;
        end else if (v) begin
            if (idx < 7) begin
                m_seg = 7'(2 ** idx);
                m_an  = 4'(2 ** m_digit);
                if (idx == 6) m_digit = (m_digit + 1) % N_DIGITS;
            end else begin
                m_seg = '0; m_an = '0; m_err = 1;
            end
        end
    endtask

    // Drive one cycle of stimulus (from just after an edge), update the model at
    // the edge, and return 1 ns after it so outputs are sampled off the edge.
    task automatic step(input bit act, input bit v, input logic [3:0] idx,
                        input logic [6:0] ns, input logic [3:0] na);
        activity = act; idx_valid = v; seg_idx = idx; normal_seg = ns; normal_an = na;
        @(posedge clk);
        model_step(act, v, int'(idx), ns, na);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 7'($urandom), 4'($urandom));
    endtask

    // Idle until the model reports saver mode (bounded).
    task automatic go_saver();
        for (int i = 0; i < IDLE + 1; i++) begin
            if (m_saver) break;
            idle_step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; activity = 0; idx_valid = 0; seg_idx = 0;
        normal_seg = 7'h55; normal_an = 4'hA;
        model_reset();
        #2;
        n_checks++;
        if (observed() !== pins(0, 0, 4'h0, 7'h00)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", observed(), pins(0, 0, 4'h0, 7'h00));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_idle_entry();
        for (int i = 1; i <= IDLE; i++) begin
            idle_step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL idle_entry cycle %0d: got %h expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (observed() !== pins(1, 0, 4'h0, 7'h00)) begin
            n_fail++;
            $display("FAIL idle_entry_saver: got %h expected %h", observed(), pins(1, 0, 4'h0, 7'h00));
        end
    endtask

    task automatic test_walk();
        logic [12:0] want;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 7; i++) begin
                step(1'b0, 1'b1, 4'(i), 7'($urandom), 4'($urandom));
                want = pins(1, 0, 4'(1 << (p % N_DIGITS)), 7'(1 << i));
                n_checks++;
                if (observed() !== want) begin
                    n_fail++;
                    $display("FAIL walk pass %0d idx %0d: got %h expected %h", p, i, observed(), want);
                end
                if (i == 3) begin
                    idle_step();
                    n_checks++;
                    if (observed() !== want) begin
                        n_fail++;
                        $display("FAIL walk_hold pass %0d: got %h expected %h", p, observed(), want);
                    end
                end
            end
        end
    endtask

    task automatic test_bad_idx();
        // Digit position is 1 after five full passes.
        step(1'b0, 1'b1, 4'($urandom_range(7, 15)), 7'($urandom), 4'($urandom));
        n_checks++;
        if (observed() !== pins(1, 1, 4'h0, 7'h00)) begin
            n_fail++;
            $display("FAIL bad_idx_blank: got %h expected %h", observed(), pins(1, 1, 4'h0, 7'h00));
        end
        step(1'b0, 1'b1, 4'd2, 7'($urandom), 4'($urandom));
        n_checks++;
        if (observed() !== pins(1, 1, 4'b0010, 7'h04)) begin
            n_fail++;
            $display("FAIL bad_idx_resume: got %h expected %h", observed(), pins(1, 1, 4'b0010, 7'h04));
        end
    endtask

    task automatic test_exit();
        step(1'b1, 1'b0, 4'd0, 7'h3F, 4'b0001);
        n_checks++;
        if (observed() !== pins(0, 0, 4'b0010, 7'h04)) begin
            n_fail++;
            $display("FAIL exit_mode: got %h expected %h", observed(), pins(0, 0, 4'b0010, 7'h04));
        end
        step(1'b0, 1'b0, 4'd0, 7'h3F, 4'b0001);
        n_checks++;
        if (observed() !== pins(0, 0, 4'b0001, 7'h3F)) begin
            n_fail++;
            $display("FAIL exit_passthrough: got %h expected %h", observed(), pins(0, 0, 4'b0001, 7'h3F));
        end
    endtask

    task automatic test_timeout_tie();
        step(1'b1, 1'b0, 4'd0, 7'($urandom), 4'($urandom));
        for (int i = 0; i < IDLE - 1; i++) idle_step();
        // Idle count is now at its last value; activity must win.
        step(1'b1, 1'b0, 4'd0, 7'h12, 4'h4);
        n_checks++;
        if (observed() !== pins(0, 0, 4'h4, 7'h12)) begin
            n_fail++;
            $display("FAIL tie_stays_normal: got %h expected %h", observed(), pins(0, 0, 4'h4, 7'h12));
        end
        for (int i = 1; i <= IDLE; i++) begin
            idle_step();
            n_checks++;
            if (saver_active !== (i == IDLE)) begin
                n_fail++;
                $display("FAIL tie_reentry cycle %0d: got %b expected %b", i, saver_active, (i == IDLE));
            end
        end
    endtask

    task automatic test_ignored_strobes();
        // Strobe together with activity in saver: leave, display untouched.
        step(1'b1, 1'b1, 4'd3, 7'h7F, 4'hF);
        n_checks++;
        if (observed() !== pins(0, 0, 4'h0, 7'h00)) begin
            n_fail++;
            $display("FAIL strobe_with_activity: got %h expected %h", observed(), pins(0, 0, 4'h0, 7'h00));
        end
        // Strobes in normal mode: no flag, no pointer motion.
        step(1'b0, 1'b1, 4'd9, 7'h21, 4'h2);
        step(1'b0, 1'b1, 4'd6, 7'h33, 4'h8);
        n_checks++;
        if (observed() !== pins(0, 0, 4'h8, 7'h33)) begin
            n_fail++;
            $display("FAIL strobe_in_normal: got %h expected %h", observed(), pins(0, 0, 4'h8, 7'h33));
        end
        go_saver();
        step(1'b0, 1'b1, 4'd0, 7'($urandom), 4'($urandom));
        n_checks++;
        if (observed() !== pins(1, 0, 4'b0001, 7'h01)) begin
            n_fail++;
            $display("FAIL normal_strobe_no_ptr: got %h expected %h", observed(), pins(1, 0, 4'b0001, 7'h01));
        end
    endtask

    task automatic test_random();
        bit         act, v;
        logic [3:0] idx;
        for (int c = 0; c < 600; c++) begin
            act = ($urandom_range(0, 19) == 0);
            v   = ($urandom_range(0, 2) == 0);
            idx = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15))
                                              : 4'($urandom_range(0, 6));
            step(act, v, idx, 7'($urandom), 4'($urandom));
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", c, observed(), expected());
            end
        end
    endtask

    task automatic test_async_reset();
        if (!m_saver) go_saver();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'(i), 7'($urandom), 4'($urandom));
        step(1'b0, 1'b1, 4'd3, 7'($urandom), 4'($urandom));
        step(1'b0, 1'b1, 4'd12, 7'($urandom), 4'($urandom));
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (observed() !== pins(0, 0, 4'h0, 7'h00)) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", observed(), pins(0, 0, 4'h0, 7'h00));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        go_saver();
        step(1'b0, 1'b1, 4'd5, 7'($urandom), 4'($urandom));
        n_checks++;
        if (observed() !== pins(1, 0, 4'b0001, 7'h20)) begin
            n_fail++;
            $display("FAIL reset_clears_ptr: got %h expected %h", observed(), pins(1, 0, 4'b0001, 7'h20));
        end
    endtask

    initial begin
        test_reset();
        test_idle_entry();
        test_walk();
        test_bad_idx();
        test_exit();
        test_timeout_tie();
        test_ignored_strobes();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
